// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//
// Purpose: groups the two valid/ready channels of an elastic pipeline
// register into one bundle. The environment side (producer of in_*, consumer
// of out_*) uses the master modport; the register block uses the slave one.
//
// Parameters:
//   WIDTH      payload width in bits
//
// Signals:
//   in_valid   upstream presents in_data
//   in_ready   block accepts in_data this cycle
//   in_data    payload in (WIDTH bits)
//   out_valid  out_data holds a valid item
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload out (WIDTH bits)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment view: drives the input payload and the output acceptance.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Register-block view.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose: parametrised elastic pipeline register. A WIDTH-bit payload moves
// through DEPTH register stages under a valid/ready handshake. Empty stages
// always accept, so a stall at the output lets upstream items advance until
// every stage is full (bubble collapsing). A synchronous flush clears every
// valid bit; a synchronous reset also loads RESET_VAL into every data
// register. Used between datapath stages of the pipelined MIPS core
// (IF/ID, ID/EX payload registers).
//
// Parameters:
//   WIDTH      payload width in bits (>= 1); must match the interface WIDTH
//   DEPTH      number of register stages (>= 1)
//   RESET_VAL  value loaded into every stage data register on reset
//
// Ports:
//   clk        clock, all state changes on posedge
//   reset      synchronous active-high reset, has priority over flush
//   flush      synchronous clear of all valid bits; blocks input and output
//   bus        pipe_stage_reg_if.slave: in_valid/in_ready/in_data,
//              out_valid/out_ready/out_data
//   occupancy  (PIPE_STAGE_REG_OCC_EN only) number of valid stages
//   full       (PIPE_STAGE_REG_OCC_EN only) occupancy == DEPTH
//
// Configuration macro:
//   PIPE_STAGE_REG_OCC_EN  when defined, adds the occupancy counter and the
//                          occupancy/full output ports. When undefined the
//                          ports and the counter are absent.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pipe_stage_reg_if.slave        bus
`ifdef PIPE_STAGE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full
`endif
);

  // -------------------------------------------------------------------------
  // Stage state. Stage 0 takes the input, stage DEPTH-1 drives the output.
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  // Per-stage ready: stage k may load this cycle.
  logic [DEPTH-1:0] rdy;

  // Source of each stage: index k holds what stage k would load, i.e. the
  // input for k = 0 and stage k-1 otherwise. Padding the chain by one entry
  // avoids any special case (and any negative index) for stage 0.
  logic [DEPTH:0]   v_chain;
  logic [WIDTH-1:0] d_chain [DEPTH+1];

  genvar gi;

  // -------------------------------------------------------------------------
  // Ready chain.
  // The recurrence rdy[k] = rdy[k+1] | ~v[k] with rdy[DEPTH-1] =
  // out_ready | ~v[DEPTH-1] unrolls to "downstream accepts, or some stage at
  // or after k is empty". Writing it in closed form keeps each bit a single
  // reduction instead of a long combinational ripple through a shared vector.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rdy
      assign rdy[gi] = bus.out_ready | ~(&v_q[DEPTH-1:gi]);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Source chain.
  // -------------------------------------------------------------------------
  assign v_chain    = {v_q, bus.in_valid};
  assign d_chain[0] = bus.in_data;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_src
      assign d_chain[gi+1] = d_q[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic.
  // Flush clears every valid bit but leaves the data registers alone. With no
  // flush, a ready stage loads its source unconditionally: the data register
  // follows even an invalid source, which keeps the enable logic down to the
  // ready bit alone. A stage that is not ready holds data and valid.
  // -------------------------------------------------------------------------
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        v_d[k] = 1'b0;
      end else if (rdy[k]) begin
        v_d[k] = v_chain[k];
        d_d[k] = d_chain[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage registers. Reset wins over flush and over every load.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake outputs.
  // Flush masks both sides so nothing is accepted or delivered in the cycle
  // whose edge discards the contents.
  // -------------------------------------------------------------------------
  assign bus.in_ready  = rdy[0] & ~flush;
  assign bus.out_valid = v_q[DEPTH-1] & ~flush;
  assign bus.out_data  = d_q[DEPTH-1];

`ifdef PIPE_STAGE_REG_OCC_EN
  // -------------------------------------------------------------------------
  // Occupancy counter.
  // Tracks the number of set valid bits. Bubble collapsing moves items
  // without changing the count, so only the boundary transfers matter:
  // +1 on an input transfer, -1 on an output transfer. Both transfers are
  // masked during flush, and flush itself empties every stage, so the count
  // simply returns to zero.
  // -------------------------------------------------------------------------
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == OCC_W'(DEPTH));
`endif

endmodule
